// File: rtl/seed_link.sv
// seed_link
//   Seed exchange stage beside generate_point. Sends the local seed to the
//   peer as a two-byte tagged frame, {TAG_X,x} then {TAG_Y,y}, over a byte
//   UART. It also parses frames from the peer into the remote seed outputs.
//
// Ports
//   clk_75, rst_n          system clock, async active-low reset
//   seed_rdy               one-cycle request to send the local seed
//   seed_x, seed_y         local seed (5 bits each)
//   tx_data, tx_start      byte and one-cycle start pulse to the UART TX
//   tx_done                one-cycle pulse when the UART has sent the byte
//   rx_data, rx_valid      received byte and its one-cycle strobe
//   seed_x_in, seed_y_in   last complete remote seed
//   remote_seed_valid      one-cycle pulse when a full frame is accepted
//   rx_error               one-cycle pulse on timeout or bad byte mid-frame
//   link_busy              high while a TX frame is in progress
//
// TX FSM
//   state      | meaning
//   TX_IDLE    | no frame in flight
//   TX_X       | X byte start pulse is on the UART interface
//   TX_WAIT_X  | waiting for tx_done of the X byte
//   TX_Y       | Y byte start pulse is on the UART interface
//   TX_WAIT_Y  | waiting for tx_done of the Y byte
// RX FSM
//   state      | meaning
//   RX_X       | hunting for an X byte
//   RX_Y       | X held, waiting for the Y byte within RX_TIMEOUT cycles
module seed_link #(
  parameter logic [2:0] TAG_X      = 3'b101,
  parameter logic [2:0] TAG_Y      = 3'b110,
  parameter int         RX_TIMEOUT = 75_000
) (
  input  logic       clk_75,
  input  logic       rst_n,
  input  logic       seed_rdy,
  input  logic [4:0] seed_x,
  input  logic [4:0] seed_y,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] seed_x_in,
  output logic [4:0] seed_y_in,
  output logic       remote_seed_valid,
  output logic       rx_error,
  output logic       link_busy
);

  localparam int CNT_W = (RX_TIMEOUT > 2) ? $clog2(RX_TIMEOUT) : 1;
  // Registered error must show RX_TIMEOUT cycles after the X byte, so the
  // decision is taken one count early.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RX_TIMEOUT - 2);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_X,
    TX_WAIT_X,
    TX_Y,
    TX_WAIT_Y
  } tx_state_t;

  typedef enum logic {
    RX_X,
    RX_Y
  } rx_state_t;

  // ---------------------------------------------------------------- TX
  tx_state_t  tx_state, tx_state_nxt;
  logic       pending, pending_nxt;
  logic [4:0] snap_x, snap_x_nxt;
  logic [4:0] snap_y, snap_y_nxt;
  logic [4:0] frame_y, frame_y_nxt;
  logic       tx_start_nxt;
  logic [7:0] tx_data_nxt;

  always_comb begin
    tx_state_nxt = tx_state;
    pending_nxt  = pending;
    snap_x_nxt   = snap_x;
    snap_y_nxt   = snap_y;
    frame_y_nxt  = frame_y;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;

    if (seed_rdy) begin
      snap_x_nxt = seed_x;
      snap_y_nxt = seed_y;
      if (tx_state != TX_IDLE) pending_nxt = 1'b1;
    end

    case (tx_state)
      TX_IDLE: begin
        if (seed_rdy) begin
          // X byte goes out straight from the inputs; only Y needs a copy.
          frame_y_nxt  = seed_y;
          tx_data_nxt  = {TAG_X, seed_x};
          tx_start_nxt = 1'b1;
          tx_state_nxt = TX_X;
        end
      end
      TX_X: tx_state_nxt = TX_WAIT_X;
      TX_WAIT_X: begin
        if (tx_done) begin
          tx_data_nxt  = {TAG_Y, frame_y};
          tx_start_nxt = 1'b1;
          tx_state_nxt = TX_Y;
        end
      end
      TX_Y: tx_state_nxt = TX_WAIT_Y;
      TX_WAIT_Y: begin
        if (tx_done) begin
          // A request in this very cycle counts as pending too, and its
          // seeds are the newest snapshot.
          if (pending || seed_rdy) begin
            pending_nxt  = 1'b0;
            frame_y_nxt  = snap_y_nxt;
            tx_data_nxt  = {TAG_X, snap_x_nxt};
            tx_start_nxt = 1'b1;
            tx_state_nxt = TX_X;
          end else begin
            tx_state_nxt = TX_IDLE;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_75 or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      pending   <= 1'b0;
      snap_x    <= '0;
      snap_y    <= '0;
      frame_y   <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      link_busy <= 1'b0;
    end else begin
      tx_state  <= tx_state_nxt;
      pending   <= pending_nxt;
      snap_x    <= snap_x_nxt;
      snap_y    <= snap_y_nxt;
      frame_y   <= frame_y_nxt;
      tx_start  <= tx_start_nxt;
      tx_data   <= tx_data_nxt;
      link_busy <= (tx_state_nxt != TX_IDLE);
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [4:0]       x_tmp, x_tmp_nxt;
  logic [4:0]       seed_x_in_nxt, seed_y_in_nxt;
  logic             rsv_nxt, rx_error_nxt;
  logic [2:0]       rx_tag;

  assign rx_tag = rx_data[7:5];

  always_comb begin
    rx_state_nxt  = rx_state;
    rx_cnt_nxt    = rx_cnt;
    x_tmp_nxt     = x_tmp;
    seed_x_in_nxt = seed_x_in;
    seed_y_in_nxt = seed_y_in;
    rsv_nxt       = 1'b0;
    rx_error_nxt  = 1'b0;

    case (rx_state)
      RX_X: begin
        if (rx_valid && rx_tag == TAG_X) begin
          x_tmp_nxt    = rx_data[4:0];
          rx_cnt_nxt   = '0;
          rx_state_nxt = RX_Y;
        end
      end
      RX_Y: begin
        // A byte takes priority over an expiring timeout.
        if (rx_valid) begin
          if (rx_tag == TAG_Y) begin
            seed_x_in_nxt = x_tmp;
            seed_y_in_nxt = rx_data[4:0];
            rsv_nxt       = 1'b1;
            rx_state_nxt  = RX_X;
          end else if (rx_tag == TAG_X) begin
            x_tmp_nxt  = rx_data[4:0];
            rx_cnt_nxt = '0;
          end else begin
            rx_error_nxt = 1'b1;
            rx_state_nxt = RX_X;
          end
        end else if (rx_cnt == CNT_LAST) begin
          rx_error_nxt = 1'b1;
          rx_state_nxt = RX_X;
        end else if (rx_cnt != '1) begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      default: rx_state_nxt = RX_X;
    endcase
  end

  always_ff @(posedge clk_75 or negedge rst_n) begin
    if (!rst_n) begin
      rx_state          <= RX_X;
      rx_cnt            <= '0;
      x_tmp             <= '0;
      seed_x_in         <= '0;
      seed_y_in         <= '0;
      remote_seed_valid <= 1'b0;
      rx_error          <= 1'b0;
    end else begin
      rx_state          <= rx_state_nxt;
      rx_cnt            <= rx_cnt_nxt;
      x_tmp             <= x_tmp_nxt;
      seed_x_in         <= seed_x_in_nxt;
      seed_y_in         <= seed_y_in_nxt;
      remote_seed_valid <= rsv_nxt;
      rx_error          <= rx_error_nxt;
    end
  end

endmodule
